// File: rtl/tpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_cmd_sequencer
//
// Instruction front-end for the TPU core. Instructions are queued in a FIFO and
// issued one at a time. After each issue the sequencer waits an opcode-specific
// latency and captures the core result, tagged with the opcode and a sequence
// number, into an output slot that holds until the consumer takes it. Illegal
// opcodes are never started on the core; they produce an error result instead.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     instruction offered
//   in_ready     FIFO can accept (never during reset or flush)
//   in_instr     instruction, opcode in the top 8 bits
//   flush        drop every queued instruction (the in-flight one completes)
//   core_instr   instruction presented to the core, stable from issue to capture
//   core_start   one-cycle issue pulse
//   core_result  core result, sampled when the opcode latency expires
//   out_valid    result slot full
//   out_ready    consumer accepts the result
//   out_result   captured result (0 for an illegal opcode)
//   out_opcode   opcode of the captured result
//   out_tag      issue sequence number
//   out_err      result belongs to an illegal opcode
//   busy         sequencer active or instructions queued
//   queue_count  FIFO occupancy
// -----------------------------------------------------------------------------
module tpu_cmd_sequencer #(
    parameter int INSTR_W  = 32,
    parameter int RES_W    = 32,
    parameter int DEPTH    = 8,
    parameter int TAG_W    = 4,
    parameter int LAT_MMA  = 2,
    parameter int LAT_CONV = 4,
    parameter int LAT_ATTN = 6,
    parameter int LAT_MEM  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       core_instr,
    output logic                     core_start,
    input  logic [RES_W-1:0]         core_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_result,
    output logic [7:0]               out_opcode,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam int              CNT_W      = 16;
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    // FIFO storage and pointers. DEPTH is a power of two, so the pointers wrap
    // naturally and full/empty come from the separate occupancy counter.
    logic [INSTR_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;

    // Opcode decode of the instruction currently held for the core.
    logic [7:0]         cur_op;
    logic               op_legal;
    logic [CNT_W-1:0]   op_lat;

    logic [CNT_W-1:0]   wait_cnt;
    logic [TAG_W-1:0]   tag_cnt;

    assign cur_op = core_instr[INSTR_W-1 -: 8];
    assign push   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Opcode decode: legality and wait latency in cycles.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        op_legal = 1'b1;
        op_lat   = CNT_W'(1);
        case (cur_op)
            8'h03, 8'h04: op_lat = CNT_W'(LAT_MMA);
            8'h30:        op_lat = CNT_W'(LAT_MMA + 1);
            8'h20:        op_lat = CNT_W'(LAT_CONV);
            8'h21:        op_lat = CNT_W'(LAT_ATTN);
            8'h10, 8'h11: op_lat = CNT_W'(LAT_MEM);
            default:      op_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else if (flush) begin
            // in_ready and pop are both held low while flush is high, so no
            // transfer competes with the clear.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   queue_count <= queue_count + (PTR_W + 1)'(1);
                2'b01:   queue_count <= queue_count - (PTR_W + 1)'(1);
                default: queue_count <= queue_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: flops are written with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An illegal opcode skips the core entirely and reports at once.
                state_next = op_legal ? S_WAIT : S_HOLD;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid && out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // in_ready is gated by rst so that it reads 0 while reset is held,
        // even though the FIFO is empty at that time.
        in_ready   = rst && (queue_count < FULL_COUNT) && !flush;
        pop        = (state == S_IDLE) && (queue_count != '0) && !flush;
        core_start = (state == S_ISSUE) && op_legal;
        busy       = (state != S_IDLE) || (queue_count != '0);
    end

    // -------------------------------------------------------------------------
    // Issue, latency counting, result capture and tag sequencing
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_instr <= '0;
            wait_cnt   <= '0;
            tag_cnt    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The output slot is always empty in IDLE, so the tag for
                    // the next result can be latched right at issue.
                    if (pop) begin
                        core_instr <= fifo_mem[rd_ptr];
                        out_tag    <= tag_cnt;
                    end
                end
                S_ISSUE: begin
                    if (op_legal) begin
                        // Counting down to 0 inclusive gives exactly op_lat
                        // cycles between core_start and the capture edge.
                        wait_cnt <= op_lat - CNT_W'(1);
                    end else begin
                        out_result <= '0;
                        out_opcode <= cur_op;
                        out_err    <= 1'b1;
                        out_valid  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        out_result <= core_result;
                        out_opcode <= cur_op;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        tag_cnt   <= tag_cnt + TAG_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tpu_cmd_sequencer
//
// Directed bench for tpu_cmd_sequencer. A small core model returns each result
// only in the cycle its opcode latency expires, and a scoreboard queue holds
// the expected result for every accepted instruction, compared on each output
// handshake.
// -----------------------------------------------------------------------------
module tb_tpu_cmd_sequencer;

    localparam int INSTR_W = 32;
    localparam int RES_W   = 32;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 4;

    localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;
    localparam logic [7:0]  LEGAL_OPS [7] = '{8'h03, 8'h04, 8'h30, 8'h20, 8'h21, 8'h11, 8'h10};

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr = '0;
    logic                 flush = 1'b0;
    logic [INSTR_W-1:0]   core_instr;
    logic                 core_start;
    logic [RES_W-1:0]     core_result = GARBAGE;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [RES_W-1:0]     out_result;
    logic [7:0]           out_opcode;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_err;
    logic                 busy;
    logic [$clog2(DEPTH):0] queue_count;

    tpu_cmd_sequencer #(
        .INSTR_W  (INSTR_W),
        .RES_W    (RES_W),
        .DEPTH    (DEPTH),
        .TAG_W    (TAG_W),
        .LAT_MMA  (2),
        .LAT_CONV (4),
        .LAT_ATTN (6),
        .LAT_MEM  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .core_instr  (core_instr),
        .core_start  (core_start),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_opcode  (out_opcode),
        .out_tag     (out_tag),
        .out_err     (out_err),
        .busy        (busy),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Reference latency table; 0 marks an illegal opcode.
    function automatic int exp_lat(input logic [7:0] op);
        case (op)
            8'h03, 8'h04: return 2;
            8'h30:        return 3;
            8'h20:        return 4;
            8'h21:        return 6;
            8'h10, 8'h11: return 3;
            default:      return 0;
        endcase
    endfunction

    typedef struct {
        logic [7:0]       op;
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               lat;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] next_tag = '0;

    // Cycle index: during cycle X, cyc == X.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- core model
    int         cm_remain = 0;
    logic [7:0] cm_op = '0;
    int         last_start = 0;
    int         starts = 0;

    always @(negedge clk) begin
        if (!rst) begin
            cm_remain   <= 0;
            core_result <= GARBAGE;
        end else if (core_start) begin
            cm_remain   <= exp_lat(core_instr[31:24]);
            cm_op       <= core_instr[31:24];
            last_start  <= cyc;
            starts      <= starts + 1;
            core_result <= GARBAGE;
        end else if (cm_remain == 1) begin
            core_result <= {16'hCAFE, 8'h00, cm_op};
            cm_remain   <= 0;
        end else begin
            core_result <= GARBAGE;
            if (cm_remain > 0) cm_remain <= cm_remain - 1;
        end
    end

    // ---------------------------------------------------------------- output monitor
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic [31:0]      prev_result = '0;
    logic [7:0]       prev_opcode = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    logic             prev_err = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid && sb.size() != 0 && !sb[0].err) begin
                check("lat_gap", 64'(cyc - last_start - 1), 64'(sb[0].lat));
            end
            if (out_valid && prev_valid && !prev_ready) begin
                check("hold_result", 64'(out_result), 64'(prev_result));
                check("hold_opcode", 64'(out_opcode), 64'(prev_opcode));
                check("hold_tag",    64'(out_tag),    64'(prev_tag));
                check("hold_err",    64'(out_err),    64'(prev_err));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_result", 64'(out_result), 64'(e.res));
                    check("out_opcode", 64'(out_opcode), 64'(e.op));
                    check("out_tag",    64'(out_tag),    64'(e.tag));
                    check("out_err",    64'(out_err),    64'(e.err));
                end
            end
            prev_valid  <= out_valid;
            prev_ready  <= out_ready;
            prev_result <= out_result;
            prev_opcode <= out_opcode;
            prev_tag    <= out_tag;
            prev_err    <= out_err;
        end
    end

    // ---------------------------------------------------------------- helpers
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [31:0] ins, output int waited);
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("push_accept", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.op  = ins[31:24];
        e.lat = exp_lat(e.op);
        e.err = (e.lat == 0);
        e.res = e.err ? 32'h0 : {16'hCAFE, 8'h00, e.op};
        e.tag = next_tag;
        next_tag = next_tag + 1'b1;
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 400) begin
            n++;
            @(negedge clk);
        end
        check({name, "_idle"},     64'(busy),      64'd0);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_in_ready"},    64'(in_ready),    64'd0);
        check({name, "_out_valid"},   64'(out_valid),   64'd0);
        check({name, "_core_start"},  64'(core_start),  64'd0);
        check({name, "_core_instr"},  64'(core_instr),  64'd0);
        check({name, "_out_result"},  64'(out_result),  64'd0);
        check({name, "_out_opcode"},  64'(out_opcode),  64'd0);
        check({name, "_out_tag"},     64'(out_tag),     64'd0);
        check({name, "_out_err"},     64'(out_err),     64'd0);
        check({name, "_busy"},        64'(busy),        64'd0);
        check({name, "_queue_count"}, 64'(queue_count), 64'd0);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_zero_outputs(name);
        sb.delete();
        next_tag = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_held_in_ready"}, 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int w;
        int s0;
        int n;
        int legal_cnt;
        logic [7:0] op;

        // 1. Reset held for two cycles, then released.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("t1_reset");
        #2 rst = 1'b1;
        @(negedge clk);
        check("t1_rel_in_ready", 64'(in_ready), 64'd1);
        check("t1_rel_busy",     64'(busy),     64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // 2. Single FP16 MMA with exact cycle timing (accepted at end of A).
        push(32'h0301_2000, w);
        @(negedge clk);  // A+1
        check("t2_start_a1", 64'(core_start), 64'd0);
        @(negedge clk);  // A+2
        check("t2_start_a2", 64'(core_start), 64'd1);
        check("t2_core_instr", 64'(core_instr), 64'h0301_2000);
        @(negedge clk);  // A+3
        check("t2_start_a3", 64'(core_start), 64'd0);
        check("t2_valid_a3", 64'(out_valid),  64'd0);
        @(negedge clk);  // A+4
        check("t2_valid_a4", 64'(out_valid),  64'd0);
        @(negedge clk);  // A+5
        check("t2_valid_a5", 64'(out_valid),  64'd1);
        check("t2_result",   64'(out_result), 64'hCAFE_0003);
        check("t2_opcode",   64'(out_opcode), 64'h03);
        check("t2_tag",      64'(out_tag),    64'd0);
        check("t2_err",      64'(out_err),    64'd0);
        wait_idle("t2");

        // 3. Seven legal opcodes back-to-back; no input stall expected.
        for (int i = 0; i < 7; i++) begin
            push({LEGAL_OPS[i], 24'h01_2000}, w);
            check("t3_no_stall", 64'(w), 64'd0);
        end
        wait_idle("t3");

        // 4. Output stalled: first op holds, FIFO fills to DEPTH, then drains.
        out_ready = 1'b0;
        legal_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            op = (i == 5) ? 8'h55 : LEGAL_OPS[i % 7];
            if (i > 0 && exp_lat(op) != 0) legal_cnt++;
            push({op, 24'(i)}, w);
            check("t4_no_stall", 64'(w), 64'd0);
        end
        @(negedge clk);
        check("t4_full_count", 64'(queue_count), 64'd8);
        check("t4_full_ready", 64'(in_ready),    64'd0);
        check("t4_holding",    64'(out_valid),   64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = 32'h0400_0009;
        repeat (3) begin
            @(negedge clk);
            check("t4_blocked_ready", 64'(in_ready),    64'd0);
            check("t4_blocked_count", 64'(queue_count), 64'd8);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        s0        = starts;
        out_ready = 1'b1;
        wait_idle("t4");
        check("t4_drain_starts", 64'(starts - s0), 64'(legal_cnt));

        // 5. Illegal opcode, then 17 legal ops to wrap the tag counter.
        do_reset("t5_reset");
        out_ready = 1'b1;
        s0 = starts;
        push(32'hFF00_0000, w);
        @(negedge clk);  // A+1
        check("t5_valid_a1", 64'(out_valid), 64'd0);
        @(negedge clk);  // A+2
        check("t5_start_a2", 64'(core_start), 64'd0);
        check("t5_valid_a2", 64'(out_valid),  64'd0);
        @(negedge clk);  // A+3
        check("t5_valid_a3", 64'(out_valid),  64'd1);
        check("t5_err",      64'(out_err),    64'd1);
        check("t5_result",   64'(out_result), 64'd0);
        check("t5_opcode",   64'(out_opcode), 64'hFF);
        check("t5_tag",      64'(out_tag),    64'd0);
        check("t5_no_start", 64'(starts - s0), 64'd0);
        wait_idle("t5a");
        for (int i = 0; i < 17; i++) begin
            push({LEGAL_OPS[i % 7], 24'(i)}, w);
        end
        wait_idle("t5b");
        check("t5_tag_wrapped", 64'(next_tag), 64'd2);

        // 6a. Flush while the first of five ops is in WAIT.
        do_reset("t6_reset");
        out_ready = 1'b1;
        push(32'h2101_2000, w);
        push(32'h0301_2001, w);
        push(32'h0401_2002, w);
        push(32'h1001_2003, w);
        push(32'h1101_2004, w);
        flush = 1'b1;
        @(negedge clk);
        check("t6_flush_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        while (sb.size() > 1) void'(sb.pop_back());
        next_tag = sb[0].tag + 1'b1;
        s0 = starts;
        #1 flush = 1'b0;
        @(negedge clk);
        check("t6_flush_count", 64'(queue_count), 64'd0);
        check("t6_flush_busy",  64'(busy),        64'd1);
        wait_idle("t6a");
        check("t6_no_more_start", 64'(starts - s0), 64'd0);

        // 6b. Reset asserted during WAIT.
        push(32'h2101_2000, w);
        n = 0;
        @(negedge clk);
        while (!core_start && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t6_seen_start", 64'(core_start), 64'd1);
        @(negedge clk);
        do_reset("t6_mid_reset");
        @(negedge clk);
        check("t6_after_busy",  64'(busy),      64'd0);
        check("t6_after_ready", 64'(in_ready),  64'd1);
        check("t6_after_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
